tube_scheduler: RTL

- Game-level sequencer for the three-tube scrolling datapath.
- Runs the game FSM (IDLE/RUN/PAUSE/OVER) and generates the one-cycle scroll tick consumed by the tube array.
- Assigns a pseudo-random gap height to each tube when it wraps to the right edge, and counts score as tubes pass the bird column.
- Drives a synchronous restart pulse to the tube array on every new game; sits between the button/collision logic and the tube array / VGA renderer.

---
 rtl/tube_pkg.sv | 31 +++
 rtl/tube_edge_det.sv | 43 ++++
 rtl/tube_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tube_pkg.sv
// tube_pkg
// Shared constants and types for the tube game sequencer.
//   - gameState_t : game FSM encoding (also the game_state output code)
//   - WRAP_X      : tube X value written by the tube array on wrap
//   - BIRD_X      : bird column used for scoring
//   - SCORE_MAX   : score saturation value
//   - LFSR_TAPS   : tap mask for the 16-bit Fibonacci LFSR
//   - lfsrStep()  : one LFSR advance
package tube_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } gameState_t;

  localparam logic [9:0] WRAP_X    = 10'd679;
  localparam logic [9:0] BIRD_X    = 10'd160;
  localparam logic [9:0] SCORE_MAX = 10'd999;

  // Polynomial x^16 + x^14 + x^13 + x^11 in right-shifting form:
  // taps 16/14/13/11 sit at bit positions 0/2/3/5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Feedback enters at the MSB; a nonzero state can never reach all-zero.
  function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/tube_edge_det.sv
// tube_edge_det
// Tracks one tube's X position and flags the cycle it wraps to the right
// edge or crosses the bird column.
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   clear in  restart in progress: strobes masked now and next cycle
//   posX  in  current tube X
//   wrap  out prev != WRAP_X && cur == WRAP_X
//   pass  out prev > BIRD_X && cur <= BIRD_X
module tube_edge_det (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [9:0] posX,
  output logic       wrap,
  output logic       pass
);
  import tube_pkg::*;

  logic [9:0] prevXReg;
  logic       clearDlyReg;
  logic       masked;

  // clearDlyReg resets high so the first compare after reset, made against
  // an arbitrary prevXReg, cannot fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prevXReg    <= '0;
      clearDlyReg <= 1'b1;
    end else begin
      prevXReg    <= posX;
      clearDlyReg <= clear;
    end
  end

  // The tube array reloads positions on the edge that ends the clear cycle,
  // so the jump to the reset positions lands in the cycle covered by
  // clearDlyReg and is never seen as a wrap or a pass.
  assign masked = clear | clearDlyReg;
  assign wrap   = !masked && (prevXReg != WRAP_X) && (posX == WRAP_X);
  assign pass   = !masked && (prevXReg > BIRD_X) && (posX <= BIRD_X);

endmodule

// File: rtl/tube_scheduler.sv
// tube_scheduler
// Game-level sequencer for the three-tube scrolling datapath: game FSM,
// scroll tick prescaler, per-tube random gap assignment and scoring.
// WRAP_X / BIRD_X come from tube_pkg.
// Optional macro TUBE_SPEED_RAMP_EN: scroll period shrinks with score,
// floored at MIN_PERIOD. Without it the period is fixed at BASE_PERIOD.
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   start        in   pulse: start / restart game
//   pause        in   pulse: toggle pause
//   collision    in   level: bird hit something
//   posX_tubeN   in   current X of tube N (N = 1..3)
//   time_out     out  one-cycle scroll tick
//   tubes_rst_n  out  registered active-low restart to the tube array
//   gapY_tubeN   out  gap top Y of tube N
//   score        out  tubes passed, saturating at 999
//   game_state   out  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//   game_over    out  high while in OVER
module tube_scheduler #(
  parameter int          CLK_W       = 17,
  parameter int          BASE_PERIOD = 100000,
`ifdef TUBE_SPEED_RAMP_EN
  parameter int          MIN_PERIOD  = 40000,
  parameter int          PERIOD_STEP = 5000,
  parameter int          SPEED_SHIFT = 2,
`endif
  parameter logic [9:0]  GAP_MIN     = 10'd80,
  parameter logic [7:0]  GAP_MASK    = 8'hFF,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       collision,
  input  logic [9:0] posX_tube1,
  input  logic [9:0] posX_tube2,
  input  logic [9:0] posX_tube3,
  output logic       time_out,
  output logic       tubes_rst_n,
  output logic [9:0] gapY_tube1,
  output logic [9:0] gapY_tube2,
  output logic [9:0] gapY_tube3,
  output logic [9:0] score,
  output logic [1:0] game_state,
  output logic       game_over
);
  import tube_pkg::*;

  gameState_t       stateReg, stateNext;
  logic             restart, running, gameOver;
  logic [CLK_W-1:0] countReg, period;
  logic             tick, timeOutReg, tubesRstNReg;
  logic [15:0]      lfsrReg;
  logic [9:0]       scoreReg;
  logic [10:0]      scoreSum;
  logic [1:0]       nPass;
  logic [2:0]       wrap, pass;
  logic             multiWrap;
  logic [9:0]       posX [3];
  logic [7:0]       wrapSlice [3];

  // ---------------- game FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateReg <= ST_IDLE;
    else      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:  if (start) stateNext = ST_RUN;
      // Collision wins over a simultaneous pause.
      ST_RUN:   if (collision) stateNext = ST_OVER;
                else if (pause) stateNext = ST_PAUSE;
      ST_PAUSE: if (start || pause) stateNext = ST_RUN;
      ST_OVER:  if (start) stateNext = ST_RUN;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    restart  = 1'b0;
    running  = 1'b0;
    gameOver = 1'b0;
    case (stateReg)
      ST_RUN:   running = 1'b1;
      ST_IDLE:  restart = start;
      ST_PAUSE: restart = start;
      ST_OVER:  begin restart = start; gameOver = 1'b1; end
      default:  ;
    endcase
  end

  // ---------------- scroll period ----------------
`ifdef TUBE_SPEED_RAMP_EN
  localparam int RAMP_W = CLK_W + 4;
  logic [RAMP_W-1:0] speedLevel, periodCut;

  // Wide intermediate: the cut is compared against the headroom before
  // subtracting, so the period never underflows below the floor.
  always_comb begin
    speedLevel = RAMP_W'(scoreReg >> SPEED_SHIFT);
    periodCut  = speedLevel * RAMP_W'(PERIOD_STEP);
    if (periodCut >= RAMP_W'(BASE_PERIOD - MIN_PERIOD))
      period = CLK_W'(MIN_PERIOD);
    else
      period = CLK_W'(RAMP_W'(BASE_PERIOD) - periodCut);
  end
`else
  assign period = CLK_W'(BASE_PERIOD);
`endif

  // >= rather than == so a period that shrinks below the running count
  // ends the current interval instead of letting the counter roll over.
  assign tick = running && (countReg >= period - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countReg     <= '0;
      timeOutReg   <= 1'b0;
      tubesRstNReg <= 1'b1;
      lfsrReg      <= LFSR_SEED;
    end else begin
      timeOutReg   <= tick;
      tubesRstNReg <= ~restart;
      lfsrReg      <= lfsrStep(lfsrReg);
      if (restart || tick) countReg <= '0;
      else if (running)    countReg <= countReg + 1'b1;
    end
  end

  // ---------------- per-tube edge detection and gaps ----------------
  assign posX[0] = posX_tube1;
  assign posX[1] = posX_tube2;
  assign posX[2] = posX_tube3;

  // Simultaneous wraps take different LFSR slices so tubes differ.
  assign multiWrap = (wrap[0] & wrap[1]) | (wrap[0] & wrap[2]) | (wrap[1] & wrap[2]);

  always_comb begin
    wrapSlice[0] = lfsrReg[7:0];
    wrapSlice[1] = multiWrap ? lfsrReg[15:8] : lfsrReg[7:0];
    wrapSlice[2] = multiWrap ? lfsrReg[11:4] : lfsrReg[7:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tube
      logic [9:0] gapYReg;

      tube_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .clear (~tubesRstNReg),
        .posX  (posX[gi]),
        .wrap  (wrap[gi]),
        .pass  (pass[gi])
      );

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          gapYReg <= GAP_MIN + 10'(40 + 80 * gi);
        else if (wrap[gi]) gapYReg <= GAP_MIN + {2'b00, wrapSlice[gi] & GAP_MASK};
      end
    end
  endgenerate

  // ---------------- scoring ----------------
  assign nPass    = 2'(pass[0]) + 2'(pass[1]) + 2'(pass[2]);
  assign scoreSum = {1'b0, scoreReg} + 11'(nPass);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      scoreReg <= '0;
    else if (restart)
      scoreReg <= '0;
    else if (running && (nPass != 2'd0))
      scoreReg <= (scoreSum > {1'b0, SCORE_MAX}) ? SCORE_MAX : scoreSum[9:0];
  end

  // ---------------- outputs ----------------
  assign time_out    = timeOutReg;
  assign tubes_rst_n = tubesRstNReg;
  assign gapY_tube1  = g_tube[0].gapYReg;
  assign gapY_tube2  = g_tube[1].gapYReg;
  assign gapY_tube3  = g_tube[2].gapYReg;
  assign score       = scoreReg;
  assign game_state  = stateReg;
  assign game_over   = gameOver;

endmodule
